// File: rtl/fila_param_if.sv
`default_nettype none
// ============================================================================
// Module      : fila_param_if
// Description : Bus bundle between a producer/consumer and the fila_param FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
interface fila_param_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
);
    localparam int LEN_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] data_in;
    logic             enqueue_in;
    logic             dequeue_in;
    logic             clear_in;
    logic [WIDTH-1:0] data_out;
    logic             data_valid_out;
    logic [LEN_W-1:0] len_out;
    logic             full_out;
    logic             empty_out;
    logic             almost_full_out;
    logic             overflow_out;
    logic             underflow_out;

    modport master (
        output data_in, enqueue_in, dequeue_in, clear_in,
        input  data_out, data_valid_out, len_out, full_out, empty_out,
               almost_full_out, overflow_out, underflow_out
    );

    modport slave (
        input  data_in, enqueue_in, dequeue_in, clear_in,
        output data_out, data_valid_out, len_out, full_out, empty_out,
               almost_full_out, overflow_out, underflow_out
    );
endinterface
`default_nettype wire

// File: rtl/fila_param.sv
`default_nettype none
// ============================================================================
// Module      : fila_param
// Description : Parametrised circular-buffer FIFO with status and sticky errors.
// Revision    : 1.0 - initial release
// ============================================================================
module fila_param #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - 2
) (
    input  logic         clk_10KHz,
    input  logic         reset,
    fila_param_if.slave  q
);
    localparam int             c_LEN_W = $clog2(DEPTH + 1);
    localparam int             c_PTR_W = $clog2(DEPTH);
    localparam [c_LEN_W-1:0]   c_DEPTH = c_LEN_W'(DEPTH);
    localparam [c_LEN_W-1:0]   c_AF    = c_LEN_W'(AF_LEVEL);
    localparam [c_PTR_W-1:0]   c_LAST  = c_PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_LEN_W-1:0] r_len;
    logic [WIDTH-1:0]   r_data_out;
    logic               r_valid;
    logic               r_overflow;
    logic               r_underflow;

    logic               w_enq_ok;
    logic               w_deq_ok;
    logic               w_wr_en;

    function automatic logic [c_PTR_W-1:0] f_next(input logic [c_PTR_W-1:0] ptr);
        return (ptr == c_LAST) ? '0 : ptr + 1'b1;
    endfunction

    // A full queue still accepts a write when a read frees the slot this cycle.
    assign w_enq_ok = q.enqueue_in & ((r_len < c_DEPTH) | q.dequeue_in);
    assign w_deq_ok = q.dequeue_in & (r_len != '0);
    assign w_wr_en  = ~reset & ~q.clear_in & w_enq_ok;

    always_ff @(posedge clk_10KHz) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= q.data_in;
        end
    end

    always_ff @(posedge clk_10KHz) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_len       <= '0;
            r_data_out  <= '0;
            r_valid     <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (q.clear_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_len    <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= w_deq_ok;
            if (w_deq_ok) begin
                r_data_out <= r_mem[r_rd_ptr];
                r_rd_ptr   <= f_next(r_rd_ptr);
            end
            if (w_enq_ok) begin
                r_wr_ptr <= f_next(r_wr_ptr);
            end
            case ({w_enq_ok, w_deq_ok})
                2'b10:   r_len <= r_len + 1'b1;
                2'b01:   r_len <= r_len - 1'b1;
                default: r_len <= r_len;
            endcase
            if (q.enqueue_in & ~w_enq_ok) begin
                r_overflow <= 1'b1;
            end
            if (q.dequeue_in & ~w_deq_ok) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign q.data_out        = r_data_out;
    assign q.data_valid_out  = r_valid;
    assign q.len_out         = r_len;
    assign q.full_out        = (r_len == c_DEPTH);
    assign q.empty_out       = (r_len == '0);
    assign q.almost_full_out = (r_len >= c_AF);
    assign q.overflow_out    = r_overflow;
    assign q.underflow_out   = r_underflow;
endmodule
`default_nettype wire

// File: tb/tb_fila_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_fila_param
// Description : Directed self-checking bench for fila_param (WIDTH=8, DEPTH=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fila_param;
    logic clk_10KHz = 1'b0;
    logic reset     = 1'b1;
    int   checks    = 0;
    int   errors    = 0;

    fila_param_if #(.WIDTH(8), .DEPTH(8)) bus ();

    fila_param #(.WIDTH(8), .DEPTH(8), .AF_LEVEL(6)) dut (
        .clk_10KHz (clk_10KHz),
        .reset     (reset),
        .q         (bus)
    );

    always #50 clk_10KHz = ~clk_10KHz;

    task automatic tick();
        @(posedge clk_10KHz);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic enq, input logic deq, input logic [7:0] d);
        bus.enqueue_in = enq;
        bus.dequeue_in = deq;
        bus.data_in    = d;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_len"},   32'(bus.len_out), 0);
        check({tag, "_empty"}, 32'(bus.empty_out), 1);
        check({tag, "_full"},  32'(bus.full_out), 0);
        check({tag, "_af"},    32'(bus.almost_full_out), 0);
        check({tag, "_dout"},  32'(bus.data_out), 0);
        check({tag, "_valid"}, 32'(bus.data_valid_out), 0);
        check({tag, "_ovf"},   32'(bus.overflow_out), 0);
        check({tag, "_unf"},   32'(bus.underflow_out), 0);
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 8'h00);
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        bus.clear_in = 1'b0;
        drive(1'b0, 1'b0, 8'h00);

        // Reset then idle
        tick();
        tick();
        reset = 1'b0;
        tick();
        check_reset_state("rst");

        // Fill with 0x11..0x18
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 8'(8'h11 + i));
            tick();
            check("fill_len",  32'(bus.len_out), 32'(i + 1));
            check("fill_af",   32'(bus.almost_full_out), (i + 1 >= 6) ? 1 : 0);
            check("fill_full", 32'(bus.full_out), (i == 7) ? 1 : 0);
        end
        drive(1'b1, 1'b0, 8'h99);
        tick();
        check("ovf_flag", 32'(bus.overflow_out), 1);
        check("ovf_len",  32'(bus.len_out), 8);

        // Drain in order
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, 8'h00);
            tick();
            check("drain_dout",  32'(bus.data_out), 32'(8'h11 + i));
            check("drain_valid", 32'(bus.data_valid_out), 1);
            check("drain_len",   32'(bus.len_out), 32'(7 - i));
        end
        tick();
        check("unf_flag",  32'(bus.underflow_out), 1);
        check("unf_valid", 32'(bus.data_valid_out), 0);
        check("unf_dout",  32'(bus.data_out), 32'h18);
        check("unf_empty", 32'(bus.empty_out), 1);
        drive(1'b0, 1'b0, 8'h00);
        tick();
        check("idle_valid", 32'(bus.data_valid_out), 0);

        // Wrap: enqueue 5, dequeue 3, enqueue 6, dequeue 8
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 8'(8'h21 + i));
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 8'h00);
            tick();
            check("wrap_a_dout", 32'(bus.data_out), 32'(8'h21 + i));
        end
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b0, 8'(8'h26 + i));
            tick();
        end
        check("wrap_len8", 32'(bus.len_out), 8);
        check("wrap_full", 32'(bus.full_out), 1);
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, 8'h00);
            tick();
            check("wrap_b_dout",  32'(bus.data_out), 32'(8'h24 + i));
            check("wrap_b_valid", 32'(bus.data_valid_out), 1);
        end
        drive(1'b0, 1'b0, 8'h00);
        tick();
        check("wrap_ovf",   32'(bus.overflow_out), 0);
        check("wrap_unf",   32'(bus.underflow_out), 0);
        check("wrap_empty", 32'(bus.empty_out), 1);

        // Full with simultaneous enqueue/dequeue
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 8'(8'h31 + i));
            tick();
        end
        drive(1'b1, 1'b1, 8'hAA);
        tick();
        check("fsim_dout",  32'(bus.data_out), 32'h31);
        check("fsim_valid", 32'(bus.data_valid_out), 1);
        check("fsim_len",   32'(bus.len_out), 8);
        check("fsim_ovf",   32'(bus.overflow_out), 0);
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, 8'h00);
            tick();
            check("fsim_drain", 32'(bus.data_out), (i == 7) ? 32'hAA : 32'(8'h32 + i));
        end

        // Empty with simultaneous enqueue/dequeue
        drive(1'b1, 1'b1, 8'h55);
        tick();
        check("esim_len",   32'(bus.len_out), 1);
        check("esim_unf",   32'(bus.underflow_out), 1);
        check("esim_valid", 32'(bus.data_valid_out), 0);
        check("esim_dout",  32'(bus.data_out), 32'hAA);
        drive(1'b0, 1'b1, 8'h00);
        tick();
        check("esim_pop", 32'(bus.data_out), 32'h55);
        check("esim_pop_valid", 32'(bus.data_valid_out), 1);

        // Clear with len=4 and overflow set
        do_reset();
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 1'b0, 8'(8'h41 + i));
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 8'h00);
            tick();
        end
        check("pre_clr_len", 32'(bus.len_out), 4);
        check("pre_clr_ovf", 32'(bus.overflow_out), 1);
        bus.clear_in = 1'b1;
        drive(1'b1, 1'b1, 8'hEE);
        tick();
        bus.clear_in = 1'b0;
        check("clr_len",   32'(bus.len_out), 0);
        check("clr_empty", 32'(bus.empty_out), 1);
        check("clr_ovf",   32'(bus.overflow_out), 1);
        check("clr_unf",   32'(bus.underflow_out), 0);
        check("clr_valid", 32'(bus.data_valid_out), 0);
        check("clr_dout",  32'(bus.data_out), 32'h44);
        drive(1'b1, 1'b0, 8'h66);
        tick();
        drive(1'b0, 1'b1, 8'h00);
        tick();
        check("post_clr_dout", 32'(bus.data_out), 32'h66);

        // Reset mid-burst
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 8'(8'h71 + i));
            tick();
        end
        drive(1'b1, 1'b1, 8'h77);
        reset = 1'b1;
        tick();
        check_reset_state("midrst");
        reset = 1'b0;
        drive(1'b0, 1'b0, 8'h00);
        tick();
        check("midrst_idle_valid", 32'(bus.data_valid_out), 0);
        check("midrst_idle_len",   32'(bus.len_out), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/fila_param.md
Name: fila_param

Overview:
- Parametrised successor to the team's 8x8 shift-register queue: a circular-buffer FIFO with configurable data width and depth.
- Adds full/empty/almost-full status, same-cycle enqueue+dequeue, synchronous clear, a dequeue-valid strobe and sticky overflow/underflow flags.
- Sits between producer logic and the display/consumer logic on the 10 kHz system clock.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- DEPTH, 8, number of entries (>=2, need not be a power of two).
- AF_LEVEL, DEPTH-2, almost_full_out asserts when len_out >= AF_LEVEL (1..DEPTH).

Ports:
- clk_10KHz  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset, sampled on the rising edge of clk_10KHz.
- data_in  in  WIDTH  word written on an accepted enqueue.
- enqueue_in  in  1  enqueue request, level-sampled each cycle.
- dequeue_in  in  1  dequeue request, level-sampled each cycle.
- clear_in  in  1  synchronous flush; empties the queue, keeps error flags.
- data_out  out  WIDTH  registered head word from the last accepted dequeue.
- data_valid_out  out  1  one-cycle strobe: data_out was updated this cycle.
- len_out  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.
- full_out  out  1  len_out == DEPTH.
- empty_out  out  1  len_out == 0.
- almost_full_out  out  1  len_out >= AF_LEVEL.
- overflow_out  out  1  sticky: an enqueue was rejected.
- underflow_out  out  1  sticky: a dequeue was rejected.

Behaviour:
- Storage: DEPTH x WIDTH array; write pointer wr_ptr and read pointer rd_ptr, each 0..DEPTH-1.
- Pointer wrap: a pointer equal to DEPTH-1 goes to 0 on increment. Explicit compare; no reliance on power-of-two rollover.
- Register-only status: len_out is a registered counter. full_out, empty_out and almost_full_out are decoded combinationally from len_out only.
- Reset (reset=1 at a clock edge), next-cycle values:
  - pointers 0, len_out 0, data_out 0, data_valid_out 0;
  - overflow_out 0, underflow_out 0;
  - empty_out 1, full_out 0, almost_full_out 0.
  - Array contents are don't-care.
- Priority: reset > clear_in > enqueue/dequeue. Reset mid-stream discards all contents with no data_valid_out pulse.
- clear_in=1: pointers and len_out go to 0, data_valid_out 0, data_out held. Enqueue/dequeue that cycle are ignored and not flagged as errors. Sticky flags are retained.
- Accept rules, evaluated on pre-edge len_out:
  - enq_ok = enqueue_in & (len_out < DEPTH | dequeue_in)
  - deq_ok = dequeue_in & (len_out > 0)
  - Dequeue on empty is rejected even with a simultaneous enqueue; there is no fall-through path.
- Accepted enqueue: mem[wr_ptr] <= data_in; wr_ptr advances.
- Accepted dequeue:
  - data_out <= mem[rd_ptr]; rd_ptr advances; data_valid_out <= 1 next cycle. Latency is 1 cycle from request edge to data_out/strobe.
  - When data_valid_out is not pulsing, it is 0 and data_out holds its last value.
- Occupancy update:
  - len_out +1 if enq_ok only; -1 if deq_ok only; unchanged if both or neither.
  - Simultaneous on full: both accepted, len_out stays DEPTH, and the new word occupies the freed slot. Read happens before write at the same index.
  - Simultaneous on empty: enqueue accepted, dequeue rejected, underflow_out set, len_out becomes 1.
- Error flags:
  - overflow_out sets on enqueue_in & ~enq_ok; underflow_out sets on dequeue_in & ~deq_ok.
  - Rejected operations change no other state.
  - Flags clear only on reset.
- Ordering: strict FIFO across any number of pointer wraps.
- Arithmetic: len_out never exceeds DEPTH and never goes below 0. All widths are sized so that no truncation occurs.

Test Plan:
- Reset then idle -> len_out=0, empty_out=1, full_out=0, data_out=0, all flags 0.
- Enqueue 0x11..0x18 (DEPTH=8) -> len_out reaches 8, full_out=1, almost_full_out=1 from len_out=6. A 9th enqueue of 0x99 -> overflow_out=1, len_out stays 8.
- Dequeue 8 times -> data_out 0x11..0x18 in order, each with a one-cycle data_valid_out pulse. A 9th dequeue -> underflow_out=1, data_out stays 0x18, no strobe.
- Wrap test: enqueue 5, dequeue 3, enqueue 6 (len=8), dequeue 8 -> all 11 words in order, no flags.
- Full plus simultaneous enqueue 0xAA and dequeue -> head word out, len_out stays 8, 0xAA emerges last. Empty plus simultaneous enqueue 0x55 and dequeue -> len_out=1, underflow_out=1, no strobe.
- clear_in with len_out=4 and overflow_out=1 -> len_out=0, empty_out=1, overflow_out stays 1. Then reset mid-burst -> all outputs return to reset values the next cycle.
